lr3_btn_event: RTL
==================

Name: lr3_btn_event

Overview:
Consumer-side companion to the team's button debounce filter: takes the filtered level and the press strobe and classifies gestures. It decides between short press, long press, double click and, optionally, auto-repeat while held. Each gesture is emitted as a single-cycle event pulse. It sits between the button filter outputs and the application control logic (mode/menu FSMs, counters).

Parameters:
LONG_TICKS, 8, CE ticks a press must be held to count as long press (>=2)
DBL_TICKS, 4, CE ticks after release within which a second press makes a double click (>=2)
RPT_TICKS, 3, CE ticks between auto-repeat pulses while held (>=2; used only with LR3_BTN_RPT_EN)
CNT_W, 8, tick counter width; must hold max(LONG_TICKS, DBL_TICKS, RPT_TICKS)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
CE  in  1  tick strobe, the same timebase as the filter's CE
BTN_LVL  in  1  debounced button level (filter BTN_O)
BTN_PRESS  in  1  one-cycle press strobe (filter BTN_CEO)
EV_SHORT  out  1  one-cycle pulse: single short press completed
EV_LONG  out  1  one-cycle pulse: long-press threshold reached
EV_DOUBLE  out  1  one-cycle pulse: double click detected
EV_RPT  out  1  one-cycle pulse: auto-repeat tick
HOLD  out  1  level: 1 while in HELD state

Behaviour:
- Reset: RST=1 forces state IDLE, counter 0, all outputs 0, regardless of CLK. Reset mid-gesture discards it; no event is emitted afterwards.
- Press = BTN_PRESS=1 with BTN_LVL=1. BTN_PRESS with BTN_LVL=0 is ignored. Release = BTN_LVL=0.
- Counter: cleared on every state change. Increments only on cycles with CE=1. "Expiry of N" means a CE cycle with counter == N-1.
- All outputs are registered. An event pulse is high for the single CLK cycle after its triggering edge. Event pulses are mutually exclusive.
- States and transitions:
  - IDLE:
    - press -> PRESS1.
    - BTN_LVL=1 without a press (button held at reset release) stays IDLE.
  - PRESS1:
    - release -> GAP.
    - else expiry of LONG_TICKS -> HELD and EV_LONG.
    - Release wins over a simultaneous expiry.
  - GAP:
    - press -> WAIT_REL and EV_DOUBLE.
    - else expiry of DBL_TICKS -> IDLE and EV_SHORT.
    - Press wins over a simultaneous expiry.
  - HELD:
    - release -> IDLE.
    - With the feature enabled: each expiry of RPT_TICKS -> EV_RPT, counter cleared, stay HELD.
    - HOLD=1 in this state.
  - WAIT_REL:
    - release -> IDLE.
    - No further events; a long hold after a double click produces nothing.
- CE held low freezes all timing; state changes driven by press/release still occur.
- Counter must never wrap. Saturate at all-ones as a safeguard.
- Illegal state encodings recover to IDLE on the next clock.

Optional Feature:
LR3_BTN_RPT_EN:
- Defined: HELD generates EV_RPT every RPT_TICKS CE ticks while held.
- Undefined: EV_RPT tied to 0, RPT_TICKS unused, HELD only waits for release.

Decomposition:
- Shared package lr3_btn_pkg holds:
  - state encoding constants (IDLE, PRESS1, GAP, HELD, WAIT_REL, 3-bit);
  - the event index constants (SHORT, LONG, DOUBLE, RPT) used by downstream decoders.
- One natural sub-module: lr3_tick_cnt, a CE-gated counter with synchronous clear, saturation and an "expire at N" compare output. It is instantiated once, and its limit is muxed by state.

Test Plan:
(All with LONG_TICKS=8, DBL_TICKS=4, RPT_TICKS=3, CE=1 every cycle unless stated.)
- Short press: press at t0, release 2 ticks later, no second press -> exactly one EV_SHORT, 4 ticks after release. No other event.
- Long press with repeat enabled: press, hold 20 ticks ->
  - EV_LONG on tick 8;
  - EV_RPT on ticks 11, 14, 17, 20;
  - HOLD=1 from tick 8 until release.
  - With the macro undefined: EV_LONG only, and EV_RPT never asserts.
- Double click: press, release after 2 ticks, press again after 2 gap ticks -> EV_DOUBLE one cycle after the second BTN_PRESS. Then a 20-tick hold and release -> no EV_SHORT/EV_LONG/EV_RPT.
- Boundary:
  - A second press on the same CE cycle as GAP expiry (gap tick 4) -> EV_DOUBLE, not EV_SHORT.
  - A release on the same CE cycle as LONG expiry -> no EV_LONG, then EV_SHORT after 4 more ticks.
- CE stall and reset: press, then CE=0 for 100 clocks -> no events.
  - Then RST pulse mid-HELD -> all outputs 0 immediately.
  - BTN_LVL still 1 after RST falls -> no events until release and a new press.
- Spurious strobe: BTN_PRESS=1 with BTN_LVL=0 in IDLE -> state stays IDLE, no event.

Source files
------------

// File: rtl/lr3_btn_pkg.sv
// Shared definitions for the button gesture classifier: state codes and
// event index positions used by lr3_btn_event and downstream decoders.
package lr3_btn_pkg;

    typedef logic [2:0] btn_state_t;

    localparam btn_state_t ST_IDLE     = 3'd0;
    localparam btn_state_t ST_PRESS1   = 3'd1;
    localparam btn_state_t ST_GAP      = 3'd2;
    localparam btn_state_t ST_HELD     = 3'd3;
    localparam btn_state_t ST_WAIT_REL = 3'd4;

    // Bit positions of each gesture inside an event vector
    localparam int EV_IDX_SHORT  = 0;
    localparam int EV_IDX_LONG   = 1;
    localparam int EV_IDX_DOUBLE = 2;
    localparam int EV_IDX_RPT    = 3;
    localparam int EV_COUNT      = 4;

    typedef logic [EV_COUNT-1:0] btn_ev_t;

endpackage

// File: rtl/lr3_btn_event_tick_cnt.sv
// CE-gated tick counter with synchronous clear and saturation; EXPIRE flags
// the CE cycle on which the count reaches LIMIT-1.
module lr3_tick_cnt
    import lr3_btn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             CLR,
    input  logic [CNT_W-1:0] LIMIT,
    output logic             EXPIRE
);

    logic [CNT_W-1:0] cnt;

    // Holding at all-ones keeps a forgotten counter from wrapping into a fake expiry
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (CE && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign EXPIRE = CE && (cnt == (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/lr3_btn_event.sv
// Button gesture classifier: short press, long press, double click and
// (with macro LR3_BTN_RPT_EN defined) auto-repeat while held.
module lr3_btn_event
    import lr3_btn_pkg::*;
#(
    parameter int LONG_TICKS = 8,
    parameter int DBL_TICKS  = 4,
    parameter int RPT_TICKS  = 3,
    parameter int CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_LVL,
    input  logic BTN_PRESS,
    output logic EV_SHORT,
    output logic EV_LONG,
    output logic EV_DOUBLE,
    output logic EV_RPT,
    output logic HOLD
);

    btn_state_t       state;
    btn_state_t       state_nxt;
    btn_ev_t          ev_nxt;
    btn_ev_t          ev_q;
    logic             hold_q;
    logic             pressed;
    logic             rpt_clr;
    logic             cnt_clr;
    logic             expire;
    logic [CNT_W-1:0] limit;

    assign pressed = BTN_PRESS & BTN_LVL;

    always_comb begin
        case (state)
            ST_PRESS1: limit = CNT_W'(LONG_TICKS);
            ST_GAP:    limit = CNT_W'(DBL_TICKS);
            default:   limit = CNT_W'(RPT_TICKS);
        endcase
    end

    // Release beats long expiry and a second press beats gap expiry
    always_comb begin
        state_nxt = state;
        ev_nxt    = '0;
        rpt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pressed) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!BTN_LVL) begin
                    state_nxt = ST_GAP;
                end else if (expire) begin
                    state_nxt            = ST_HELD;
                    ev_nxt[EV_IDX_LONG] = 1'b1;
                end
            end
            ST_GAP: begin
                if (pressed) begin
                    state_nxt              = ST_WAIT_REL;
                    ev_nxt[EV_IDX_DOUBLE] = 1'b1;
                end else if (expire) begin
                    state_nxt             = ST_IDLE;
                    ev_nxt[EV_IDX_SHORT] = 1'b1;
                end
            end
            ST_HELD: begin
                if (!BTN_LVL) begin
                    state_nxt = ST_IDLE;
                end
`ifdef LR3_BTN_RPT_EN
                else if (expire) begin
                    ev_nxt[EV_IDX_RPT] = 1'b1;
                    rpt_clr            = 1'b1;
                end
`endif
            end
            ST_WAIT_REL: begin
                if (!BTN_LVL) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cnt_clr = (state_nxt != state) | rpt_clr;

    lr3_tick_cnt #(
        .CNT_W(CNT_W)
    ) u_tick_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .CE    (CE),
        .CLR   (cnt_clr),
        .LIMIT (limit),
        .EXPIRE(expire)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            ev_q   <= '0;
            hold_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ev_q   <= ev_nxt;
            hold_q <= (state_nxt == ST_HELD);
        end
    end

    assign EV_SHORT  = ev_q[EV_IDX_SHORT];
    assign EV_LONG   = ev_q[EV_IDX_LONG];
    assign EV_DOUBLE = ev_q[EV_IDX_DOUBLE];
    // Without the repeat feature this bit is never set, so EV_RPT stays 0
    assign EV_RPT    = ev_q[EV_IDX_RPT];
    assign HOLD      = hold_q;

endmodule
